// File: rtl/swan256_dec_key_sequencer_pkg.sv
// Shared constants and state encoding for the SWAN256 decryption key sequencer.
package swan256_dec_key_sequencer_pkg;

   localparam int unsigned KEY_SIZE  = 256;
   localparam int unsigned SIDE_SIZE = 128;
   localparam int unsigned ROUNDS    = 64;
   localparam int unsigned RND_W     = 7;

   localparam logic [RND_W-1:0]     LastRound = RND_W'(ROUNDS - 1);
   localparam logic [0:SIDE_SIZE-1] DELTA0    = 128'h9e3779b97f4a7c15f39cc0605cedc834;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/swan256_dec_key_sequencer_step.sv
// One combinational SWAN256 decryption key-schedule step.
module dec_key_schedule_256
   import swan256_dec_key_sequencer_pkg::*;
(
   input  logic [0:KEY_SIZE-1]  key_i,
   input  logic [0:SIDE_SIZE-1] delta_i,
   output logic [0:SIDE_SIZE-1] sk_o,
   output logic [0:KEY_SIZE-1]  next_key_o,
   output logic [0:SIDE_SIZE-1] next_delta_o
);

   logic [0:SIDE_SIZE-1] diff;
   logic [0:KEY_SIZE-1]  mixed;

   assign sk_o  = key_i[SIDE_SIZE:KEY_SIZE-1];
   assign diff  = sk_o - delta_i;
   assign mixed = {key_i[0:SIDE_SIZE-1], diff};

   // Bit 0 is the MSB, so a left rotate by 120 pulls bits 120.. to the front.
   assign next_key_o   = {mixed[120:KEY_SIZE-1], mixed[0:119]};
   assign next_delta_o = delta_i - DELTA0;

endmodule

// File: rtl/swan256_dec_key_sequencer.sv
// Iterative controller emitting one SWAN256 decryption round subkey per handshake.
module swan256_dec_key_sequencer
   import swan256_dec_key_sequencer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [0:KEY_SIZE-1]  key_in_i,
   input  logic [0:SIDE_SIZE-1] delta_in_i,
   output logic [0:SIDE_SIZE-1] sk_o,
   output logic                 sk_valid_o,
   input  logic                 sk_ready_i,
   output logic [RND_W-1:0]     round_idx_o,
   output logic                 busy_o,
   output logic                 done_o
);

   state_e               state_q, state_d;
   logic [0:KEY_SIZE-1]  key_q, key_d, next_key;
   logic [0:SIDE_SIZE-1] delta_q, delta_d, next_delta, sk;
   logic [RND_W-1:0]     round_q, round_d;
   logic                 handshake;

   dec_key_schedule_256 u_step (
      .key_i        (key_q),
      .delta_i      (delta_q),
      .sk_o         (sk),
      .next_key_o   (next_key),
      .next_delta_o (next_delta)
   );

   assign handshake = (state_q == StRun) && sk_ready_i;

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      delta_d = delta_q;
      round_d = round_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               key_d   = key_in_i;
               delta_d = delta_in_i;
               round_d = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (handshake) begin
               key_d   = next_key;
               delta_d = next_delta;
               if (round_q == LastRound) begin
                  round_d = '0;
                  state_d = StDone;
               end else begin
                  round_d = round_q + RND_W'(1);
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Abort beats a same-cycle start; an accepted subkey still advances key/delta.
      if (abort_i) begin
         state_d = StIdle;
         round_d = '0;
         if (state_q == StIdle) begin
            key_d   = key_q;
            delta_d = delta_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         key_q   <= '0;
         delta_q <= '0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         delta_q <= delta_d;
         round_q <= round_d;
      end
   end

   assign sk_o        = sk;
   assign sk_valid_o  = (state_q == StRun);
   assign busy_o      = (state_q == StRun);
   assign done_o      = (state_q == StDone);
   assign round_idx_o = round_q;

endmodule

// File: tb/tb_swan256_dec_key_sequencer.sv
// Directed self-checking bench for swan256_dec_key_sequencer.
module tb_swan256_dec_key_sequencer;

   localparam logic [127:0] D0 = 128'h9e3779b97f4a7c15f39cc0605cedc834;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_i, abort_i, sk_ready_i;
   logic [255:0] key_in_i;
   logic [127:0] delta_in_i;
   logic [127:0] sk_o;
   logic         sk_valid_o, busy_o, done_o;
   logic [6:0]   round_idx_o;

   int pass_cnt = 0;
   int total_cnt = 0;

   swan256_dec_key_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .key_in_i    (key_in_i),
      .delta_in_i  (delta_in_i),
      .sk_o        (sk_o),
      .sk_valid_o  (sk_valid_o),
      .sk_ready_i  (sk_ready_i),
      .round_idx_o (round_idx_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference step: sk = low half; key' = rotl120({hi, sk - delta}); delta' = delta - D0.
   function automatic logic [255:0] mdl_key(input logic [255:0] k, input logic [127:0] d);
      logic [127:0] t;
      logic [255:0] m;
      t = k[127:0] - d;
      m = {k[255:128], t};
      return {m[135:0], m[255:136]};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; sk_ready_i = 1'b0;
      key_in_i = '0; delta_in_i = '0;
      #2;
      total_cnt++;
      if ({sk_valid_o, busy_o, done_o} !== 3'b000) $display("FAIL reset_flags got %b want 000", {sk_valid_o, busy_o, done_o});
      else pass_cnt++;
      total_cnt++;
      if (round_idx_o !== 7'd0 || sk_o !== 128'd0) $display("FAIL reset_idx_sk got %0d/%h want 0/0", round_idx_o, sk_o);
      else pass_cnt++;
      #10 rst_n = 1'b1;
      tick(); tick();
      total_cnt++;
      if (sk_valid_o !== 1'b0) $display("FAIL idle_no_valid got %b want 0", sk_valid_o);
      else pass_cnt++;
   endtask

   task automatic test_zero_vector();
      logic [127:0] exp_sk [3];
      logic [127:0] exp_delta;
      exp_sk[0] = '0; exp_sk[1] = '0; exp_sk[2] = 128'h34000000000000000000000000000000;
      key_in_i = '0; delta_in_i = '0; sk_ready_i = 1'b1;
      start_i = 1'b1; tick(); start_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         exp_delta = 128'd0 - (128'(k) * D0);
         total_cnt++;
         if (sk_valid_o !== 1'b1 || sk_o !== exp_sk[k] || round_idx_o !== 7'(k))
            $display("FAIL zero_sk%0d got v=%b idx=%0d sk=%h want v=1 idx=%0d sk=%h",
                     k, sk_valid_o, round_idx_o, sk_o, k, exp_sk[k]);
         else pass_cnt++;
         total_cnt++;
         if (dut.delta_q !== exp_delta) $display("FAIL zero_delta%0d got %h want %h", k, dut.delta_q, exp_delta);
         else pass_cnt++;
         tick();
      end
      abort_i = 1'b1; tick(); abort_i = 1'b0; sk_ready_i = 1'b0;
   endtask

   task automatic test_reset_midrun();
      key_in_i = {128'h1, 128'hfeedface}; delta_in_i = 128'h5; sk_ready_i = 1'b1;
      start_i = 1'b1; tick(); start_i = 1'b0;
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({sk_valid_o, busy_o, done_o} !== 3'b000 || round_idx_o !== 7'd0 || sk_o !== 128'd0)
         $display("FAIL midrun_reset got v/b/d=%b idx=%0d sk=%h want 000/0/0",
                  {sk_valid_o, busy_o, done_o}, round_idx_o, sk_o);
      else pass_cnt++;
      #3 rst_n = 1'b1;
      tick(); tick();
      total_cnt++;
      if (sk_valid_o !== 1'b0 || done_o !== 1'b0) $display("FAIL post_reset_quiet got v=%b d=%b want 0/0", sk_valid_o, done_o);
      else pass_cnt++;
      sk_ready_i = 1'b0;
   endtask

   task automatic test_completion();
      logic [255:0] mk;
      logic [127:0] md;
      int er = 0, hs = 0, errs = 0;
      bit seen_done = 0;
      key_in_i = 256'h00112233445566778899aabbccddeeff_0123456789abcdeffedcba9876543210;
      delta_in_i = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      mk = key_in_i; md = delta_in_i; sk_ready_i = 1'b1;
      start_i = 1'b1; tick(); start_i = 1'b0;
      for (int c = 0; c < 200 && !seen_done; c++) begin
         if (done_o) seen_done = 1;
         if (sk_valid_o) begin
            total_cnt++;
            if (sk_o !== mk[127:0] || round_idx_o !== 7'(er)) begin
               errs++;
               $display("FAIL run_sk idx=%0d sk=%h want idx=%0d sk=%h", round_idx_o, sk_o, er, mk[127:0]);
            end else pass_cnt++;
         end
         // A start mid-run with a different key must be ignored.
         if (er == 5) begin start_i = 1'b1; key_in_i = ~key_in_i; end
         else start_i = 1'b0;
         if (sk_valid_o && sk_ready_i) begin
            mk = mdl_key(mk, md); md = md - D0; er++; hs++;
         end
         if (!seen_done) tick();
      end
      total_cnt++;
      if (!seen_done || hs != 64) $display("FAIL run_handshakes got %0d done=%0d want 64 done=1", hs, seen_done);
      else pass_cnt++;
      total_cnt++;
      if (busy_o !== 1'b0 || sk_valid_o !== 1'b0) $display("FAIL done_state got b=%b v=%b want 0/0", busy_o, sk_valid_o);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (done_o !== 1'b0 || sk_valid_o !== 1'b0 || round_idx_o !== 7'd0)
         $display("FAIL after_done got d=%b v=%b idx=%0d want 0/0/0", done_o, sk_valid_o, round_idx_o);
      else pass_cnt++;
   endtask

   task automatic test_back_pressure();
      logic [255:0] mk;
      logic [127:0] md;
      int er = 0, stalls = 0, done_cyc = -1, cyc;
      key_in_i = '0; delta_in_i = '0; mk = '0; md = '0;
      start_i = 1'b1; sk_ready_i = 1'b1; tick(); start_i = 1'b0;
      cyc = 1;
      while (cyc < 150 && done_cyc < 0) begin
         if (done_o) done_cyc = cyc;
         if (sk_valid_o) begin
            total_cnt++;
            if (sk_o !== mk[127:0] || round_idx_o !== 7'(er))
               $display("FAIL bp_sk cyc=%0d idx=%0d sk=%h want idx=%0d sk=%h", cyc, round_idx_o, sk_o, er, mk[127:0]);
            else pass_cnt++;
         end
         sk_ready_i = !(er == 1 && stalls < 3);
         if (!sk_ready_i) stalls++;
         if (sk_valid_o && sk_ready_i) begin
            mk = mdl_key(mk, md); md = md - D0; er++;
         end
         tick();
         cyc++;
      end
      total_cnt++;
      if (done_cyc != 64 + 3 + 1) $display("FAIL bp_total_cycles got %0d want %0d", done_cyc, 68);
      else pass_cnt++;
   endtask

   task automatic test_abort();
      logic [255:0] newkey;
      tick();
      key_in_i = {128'habcd, 128'h1234}; delta_in_i = '0;
      start_i = 1'b1; abort_i = 1'b1; tick(); start_i = 1'b0; abort_i = 1'b0;
      total_cnt++;
      if (sk_valid_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL abort_beats_start got v=%b b=%b want 0/0", sk_valid_o, busy_o);
      else pass_cnt++;
      sk_ready_i = 1'b1; start_i = 1'b1; tick(); start_i = 1'b0;
      for (int i = 0; i < 40 && round_idx_o != 7'd10; i++) tick();
      total_cnt++;
      if (round_idx_o !== 7'd10 || sk_valid_o !== 1'b1) $display("FAIL abort_reach10 got idx=%0d v=%b want 10/1", round_idx_o, sk_valid_o);
      else pass_cnt++;
      abort_i = 1'b1; tick(); abort_i = 1'b0;
      total_cnt++;
      if ({sk_valid_o, busy_o, done_o} !== 3'b000 || round_idx_o !== 7'd0)
         $display("FAIL abort_idle got v/b/d=%b idx=%0d want 000/0", {sk_valid_o, busy_o, done_o}, round_idx_o);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (done_o !== 1'b0) $display("FAIL abort_no_done got %b want 0", done_o);
      else pass_cnt++;
      newkey = 256'hcafebabe_00000000_11111111_22222222_33333333_44444444_55555555_66666666;
      key_in_i = newkey; start_i = 1'b1; tick(); start_i = 1'b0;
      total_cnt++;
      if (sk_o !== newkey[127:0] || round_idx_o !== 7'd0 || sk_valid_o !== 1'b1)
         $display("FAIL abort_restart got v=%b idx=%0d sk=%h want 1/0/%h", sk_valid_o, round_idx_o, sk_o, newkey[127:0]);
      else pass_cnt++;
      abort_i = 1'b1; tick(); abort_i = 1'b0; sk_ready_i = 1'b0;
   endtask

   task automatic test_golden();
      logic [255:0] mk;
      logic [127:0] md;
      int er = 0, bad = 0;
      bit seen_done = 0;
      key_in_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      delta_in_i = {$urandom, $urandom, $urandom, $urandom};
      mk = key_in_i; md = delta_in_i; sk_ready_i = 1'b0;
      start_i = 1'b1; tick(); start_i = 1'b0;
      for (int c = 0; c < 1000 && !seen_done; c++) begin
         if (done_o) seen_done = 1;
         else begin
            if (sk_valid_o && (sk_o !== mk[127:0] || round_idx_o !== 7'(er))) begin
               bad++;
               if (bad < 4) $display("FAIL golden_sk idx=%0d sk=%h want idx=%0d sk=%h", round_idx_o, sk_o, er, mk[127:0]);
            end
            sk_ready_i = 1'($urandom_range(0, 1));
            if (sk_valid_o && sk_ready_i) begin
               mk = mdl_key(mk, md); md = md - D0; er++;
            end
            tick();
         end
      end
      total_cnt++;
      if (bad != 0 || er != 64 || !seen_done)
         $display("FAIL golden_run got bad=%0d accepted=%0d done=%0d want 0/64/1", bad, er, seen_done);
      else pass_cnt++;
      sk_ready_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_vector();
      test_reset_midrun();
      test_completion();
      test_back_pressure();
      test_abort();
      test_golden();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
